alu_ctrl_decode_stage: RTL
==========================

# alu_ctrl_decode_stage

Decode-side partner of the ALU: takes a fetched RV64I/Zba instruction in the ID stage and produces the 5-bit ALU operation code, operand-select controls and an illegal flag. It registers them into the ID/EX pipeline register under a valid/ready handshake. It sits between the instruction register and the execute-stage ALU, and is the only producer of the ALU's operation code.

## Interface
Parameters:
- `XLEN`, 64, datapath width. Fixed at 64; only the `Instr` width depends on the ISA.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `InstrD`  input  32  instruction word in ID.
- `ValidD`  input  1  `InstrD` holds a real instruction.
- `ReadyD`  output  1  stage can accept `InstrD` this cycle.
- `FlushE`  input  1  kill the contents of the ID/EX register (branch mispredict or trap).
- `ValidE`  output  1  ID/EX register holds a live instruction.
- `ReadyE`  input  1  EX consumes the ID/EX contents this cycle.
- `ALUControlE`  output  5  ALU operation code (encoding below).
- `ALUSrcBE`  output  1  0 selects rs2 as SrcB; 1 selects the immediate.
- `SrcASelE`  output  2  SrcA select: 00 = rs1, 01 = PC, 10 = zero.
- `IllegalE`  output  1  the registered instruction is not decodable.

## Operation
- Combinational decode of `InstrD` feeds the ID/EX register. All outputs are registered; there are no combinational paths from `InstrD` to outputs.
- ALU operation code encoding:
  - 00000 add, 00001 sub, 00010 and, 00011 or, 00100 xor.
  - 00101 sll, 00110 srl, 00111 sra (64-bit shifts).
  - 01000 addw, 01001 subw, 01100 sllw, 01101 srlw, 01110 sraw.
  - 01010 slt, 01011 sltu.
  - 10000/10001/10010 sh1add/sh2add/sh3add.
  - 10011 add.uw, 10100/10101/10110 sh1add.uw/sh2add.uw/sh3add.uw.
- OP (0110011) and OP-IMM (0010011):
  - Map from funct3 and funct7[5].
  - `ALUSrcBE` = 1 for OP-IMM.
  - funct3 = 101 with funct7[5] = 1 gives sra/srai; imm[5] is part of the 64-bit shift amount.
- OP-32 (0111011) and OP-IMM-32 (0011011) map to the W codes.
  - slliw/srliw/sraiw with imm[5] = 1 are illegal.
- Loads, stores and jalr emit 00000 with `ALUSrcBE` = 1.
- auipc emits 00000 with `SrcASelE` = 01.
- lui emits 00000 with `SrcASelE` = 10 and `ALUSrcBE` = 1.
- jal emits 00000 with `SrcASelE` = 01.
- Branches, `ALUSrcBE` = 0:
  - beq/bne emit 00001 (sub; EX tests Zero).
  - blt/bge emit 01010.
  - bltu/bgeu emit 01011.
- Any other encoding sets `IllegalE` = 1 and `ALUControlE` = 00000. The instruction still flows so that EX can trap. This includes slli.uw, which the ALU does not support.
- Handshake: `ReadyD` = !`ValidE` || `ReadyE`.
  - A transfer occurs when `ValidD` && `ReadyD`.
  - When `ValidE` && !`ReadyE`, all E outputs hold stable.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on the E outputs after edge N.
- Throughput is 1 instruction per cycle while `ReadyE` = 1.
- Reset values: `ValidE` = 0, `ALUControlE` = 00000, `ALUSrcBE` = 0, `SrcASelE` = 00, `IllegalE` = 0.
- `ReadyD` = 1 in the first cycle after reset.
- `reset` asserted mid-stream wins over everything, including `FlushE` and a pending transfer.
- `FlushE` = 1 at an edge:
  - `ValidE` <= 0 and `IllegalE` <= 0.
  - A simultaneous transfer from ID is discarded; the ID stage must re-present the instruction.
  - The other E fields may hold stale values.
- Accept with `ValidD` = 0 while `ReadyD` = 1: `ValidE` <= 0 (bubble); the field values are don't-care.
- Simultaneous consume and accept (`ValidE` = `ReadyE` = `ValidD` = 1): the new instruction replaces the old one in the same edge with no bubble.

## Configuration
- `ZBA_EN` defined: the Zba encodings decode to 10000–10110:
  - OP, funct7 = 0010000, funct3 = 010/100/110 → sh1add/sh2add/sh3add.
  - OP-32, funct7 = 0000100, funct3 = 000 → add.uw.
  - OP-32, funct7 = 0010000, funct3 = 010/100/110 → sh1add.uw/sh2add.uw/sh3add.uw.
- `ZBA_EN` undefined: those encodings set `IllegalE` = 1 and `ALUControlE` = 00000. Codes 1xxxx are never emitted.

## Test plan
- Reset held for 2 cycles then released → all outputs at their reset values, `ReadyD` = 1.
- `InstrD` = 0x403100B3 (sub x1,x2,x3), `ValidD` = 1, `ReadyE` = 1 → next cycle `ValidE` = 1, `ALUControlE` = 00001, `ALUSrcBE` = 0, `SrcASelE` = 00, `IllegalE` = 0.
- `InstrD` = 0x207342B3 (sh2add), then 0x087302BB (add.uw):
  - With `ZBA_EN`: 10001 then 10011.
  - Without `ZBA_EN`: `IllegalE` = 1 with code 00000 for both.
- Stall: `ReadyE` = 0 for 3 cycles with `ValidE` = 1 → `ReadyD` = 0 and E outputs unchanged. `ReadyE` back to 1 → the next instruction appears one cycle later and none is lost or duplicated.
- `FlushE` = 1 in the same cycle a transfer of 0x00000013 (addi) occurs → next cycle `ValidE` = 0. No instruction reaches EX until ID re-presents it.
- Sweep one instruction per opcode class (lui, auipc, jal, lw, sw, bltu, sraiw, srai) → each produces the mapped code and select values. sraiw with imm[5] = 1 → `IllegalE` = 1.

Source files
------------

// File: rtl/alu_ctrl_decode_stage.sv
// alu_ctrl_decode_stage
// ID-stage decoder for RV64I (+ optional Zba) that produces the ALU operation
// code, operand-select controls and an illegal flag, and registers them into
// the ID/EX register under a valid/ready handshake.
// Optional feature macro: ZBA_EN (enables sh*add / add.uw / sh*add.uw decode).
module alu_ctrl_decode_stage #(
    parameter int XLEN = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic        ValidD,
    output logic        ReadyD,
    input  logic        FlushE,
    output logic        ValidE,
    input  logic        ReadyE,
    output logic [4:0]  ALUControlE,
    output logic        ALUSrcBE,
    output logic [1:0]  SrcASelE,
    output logic        IllegalE
);

    localparam int SHAMT_W = $clog2(XLEN);

    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [4:0] ALU_SUB    = 5'b00001;
    localparam logic [4:0] ALU_AND    = 5'b00010;
    localparam logic [4:0] ALU_OR     = 5'b00011;
    localparam logic [4:0] ALU_XOR    = 5'b00100;
    localparam logic [4:0] ALU_SLL    = 5'b00101;
    localparam logic [4:0] ALU_SRL    = 5'b00110;
    localparam logic [4:0] ALU_SRA    = 5'b00111;
    localparam logic [4:0] ALU_ADDW   = 5'b01000;
    localparam logic [4:0] ALU_SUBW   = 5'b01001;
    localparam logic [4:0] ALU_SLT    = 5'b01010;
    localparam logic [4:0] ALU_SLTU   = 5'b01011;
    localparam logic [4:0] ALU_SLLW   = 5'b01100;
    localparam logic [4:0] ALU_SRLW   = 5'b01101;
    localparam logic [4:0] ALU_SRAW   = 5'b01110;
`ifdef ZBA_EN
    localparam logic [4:0] ALU_SH1ADD   = 5'b10000;
    localparam logic [4:0] ALU_SH2ADD   = 5'b10001;
    localparam logic [4:0] ALU_SH3ADD   = 5'b10010;
    localparam logic [4:0] ALU_ADDUW    = 5'b10011;
    localparam logic [4:0] ALU_SH1ADDUW = 5'b10100;
    localparam logic [4:0] ALU_SH2ADDUW = 5'b10101;
    localparam logic [4:0] ALU_SH3ADDUW = 5'b10110;
`endif

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OPIMMW = 7'b0011011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_OPW    = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    // Bits above the 64-bit shift amount; must be 000000 / 010000 for shifts.
    logic [31-20-SHAMT_W:0] imm_hi;
    logic       unused_fields;

    assign opcode        = InstrD[6:0];
    assign funct3        = InstrD[14:12];
    assign funct7        = InstrD[31:25];
    assign imm_hi        = InstrD[31:20+SHAMT_W];
    assign unused_fields = ^{InstrD[24:15], InstrD[11:7]};

    logic [4:0] dec_code;
    logic       dec_src_b;
    logic [1:0] dec_src_a;
    logic       dec_illegal;

    // Combinational decode of the ID instruction into ALU controls.
    always_comb begin
        dec_code    = ALU_ADD;
        dec_src_b   = 1'b0;
        dec_src_a   = 2'b00;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000:  dec_code = ALU_ADD;
                            3'b001:  dec_code = ALU_SLL;
                            3'b010:  dec_code = ALU_SLT;
                            3'b011:  dec_code = ALU_SLTU;
                            3'b100:  dec_code = ALU_XOR;
                            3'b101:  dec_code = ALU_SRL;
                            3'b110:  dec_code = ALU_OR;
                            default: dec_code = ALU_AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b000)      dec_code = ALU_SUB;
                        else if (funct3 == 3'b101) dec_code = ALU_SRA;
                        else                       dec_illegal = 1'b1;
                    end
`ifdef ZBA_EN
                    7'b0010000: begin
                        case (funct3)
                            3'b010:  dec_code = ALU_SH1ADD;
                            3'b100:  dec_code = ALU_SH2ADD;
                            3'b110:  dec_code = ALU_SH3ADD;
                            default: dec_illegal = 1'b1;
                        endcase
                    end
`endif
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                dec_src_b = 1'b1;
                case (funct3)
                    3'b000: dec_code = ALU_ADD;
                    3'b010: dec_code = ALU_SLT;
                    3'b011: dec_code = ALU_SLTU;
                    3'b100: dec_code = ALU_XOR;
                    3'b110: dec_code = ALU_OR;
                    3'b111: dec_code = ALU_AND;
                    3'b001: begin
                        if (imm_hi == 6'b000000) dec_code = ALU_SLL;
                        else                     dec_illegal = 1'b1;
                    end
                    default: begin
                        if (imm_hi == 6'b000000)      dec_code = ALU_SRL;
                        else if (imm_hi == 6'b010000) dec_code = ALU_SRA;
                        else                          dec_illegal = 1'b1;
                    end
                endcase
            end
            OPC_OPW: begin
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: dec_code = ALU_ADDW;
                    {7'b0000000, 3'b001}: dec_code = ALU_SLLW;
                    {7'b0000000, 3'b101}: dec_code = ALU_SRLW;
                    {7'b0100000, 3'b000}: dec_code = ALU_SUBW;
                    {7'b0100000, 3'b101}: dec_code = ALU_SRAW;
`ifdef ZBA_EN
                    {7'b0000100, 3'b000}: dec_code = ALU_ADDUW;
                    {7'b0010000, 3'b010}: dec_code = ALU_SH1ADDUW;
                    {7'b0010000, 3'b100}: dec_code = ALU_SH2ADDUW;
                    {7'b0010000, 3'b110}: dec_code = ALU_SH3ADDUW;
`endif
                    default:              dec_illegal = 1'b1;
                endcase
            end
            OPC_OPIMMW: begin
                // Exact funct7 match rejects imm[5] = 1 on the W shifts (and slli.uw).
                dec_src_b = 1'b1;
                case ({funct7, funct3}) inside
                    {7'b???????, 3'b000}: dec_code = ALU_ADDW;
                    {7'b0000000, 3'b001}: dec_code = ALU_SLLW;
                    {7'b0000000, 3'b101}: dec_code = ALU_SRLW;
                    {7'b0100000, 3'b101}: dec_code = ALU_SRAW;
                    default:              dec_illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec_src_b = 1'b1;
                if (funct3 == 3'b111) dec_illegal = 1'b1;
            end
            OPC_STORE: begin
                dec_src_b = 1'b1;
                if (funct3[2]) dec_illegal = 1'b1;
            end
            OPC_JALR: begin
                dec_src_b = 1'b1;
                if (funct3 != 3'b000) dec_illegal = 1'b1;
            end
            // auipc computes PC + immediate.
            OPC_AUIPC: begin
                dec_src_a = 2'b01;
                dec_src_b = 1'b1;
            end
            OPC_LUI: begin
                dec_src_a = 2'b10;
                dec_src_b = 1'b1;
            end
            OPC_JAL: dec_src_a = 2'b01;
            OPC_BRANCH: begin
                case (funct3)
                    3'b000, 3'b001: dec_code = ALU_SUB;
                    3'b100, 3'b101: dec_code = ALU_SLT;
                    3'b110, 3'b111: dec_code = ALU_SLTU;
                    default:        dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
        // Undecodable instructions travel as a plain add so EX can trap cleanly.
        if (dec_illegal) begin
            dec_code  = ALU_ADD;
            dec_src_b = 1'b0;
            dec_src_a = 2'b00;
        end
    end

    logic       valid_q, valid_d;
    logic [4:0] alu_ctrl_q, alu_ctrl_d;
    logic       src_b_q, src_b_d;
    logic [1:0] src_a_q, src_a_d;
    logic       illegal_q, illegal_d;
    logic       ready_d;

    assign ready_d = !valid_q || ReadyE;

    // Next-state of the ID/EX register: flush kills, otherwise load on a free slot.
    always_comb begin
        valid_d    = valid_q;
        alu_ctrl_d = alu_ctrl_q;
        src_b_d    = src_b_q;
        src_a_d    = src_a_q;
        illegal_d  = illegal_q;
        if (FlushE) begin
            valid_d   = 1'b0;
            illegal_d = 1'b0;
        end else if (ready_d) begin
            valid_d = ValidD;
            if (ValidD) begin
                alu_ctrl_d = dec_code;
                src_b_d    = dec_src_b;
                src_a_d    = dec_src_a;
                illegal_d  = dec_illegal;
            end
        end
    end

    // ID/EX register with synchronous reset that overrides flush and transfers.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            alu_ctrl_q <= 5'b00000;
            src_b_q    <= 1'b0;
            src_a_q    <= 2'b00;
            illegal_q  <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            alu_ctrl_q <= alu_ctrl_d;
            src_b_q    <= src_b_d;
            src_a_q    <= src_a_d;
            illegal_q  <= illegal_d;
        end
    end

    assign ReadyD      = ready_d;
    assign ValidE      = valid_q;
    assign ALUControlE = alu_ctrl_q;
    assign ALUSrcBE    = src_b_q;
    assign SrcASelE    = src_a_q;
    assign IllegalE    = illegal_q;

endmodule
